// File: rtl/hcp_report_sched_pkg.sv
// Shared definitions for the HCP report scheduler: state encoding, source
// indices and small index helpers used by the scheduler and its arbiter.
// Build option HCP_REPORT_PRIO_EN changes the round-robin pointer wrap.
package hcp_report_sched_pkg;

    localparam int SRC_NUM  = 4;
    localparam int SRC_CSM  = 0;
    localparam int SRC_NMAC = 1;

    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        REQ_S    = 2'd1,
        STREAM_S = 2'd2
    } sched_state_t;

    // Index of the set bit of a one-hot source vector.
    function automatic logic [1:0] onehot_to_idx(input logic [SRC_NUM-1:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Pointer for the next round after source g finished a frame. With the
    // priority build, source 0 is outside the rotation so the pointer skips it.
    function automatic logic [1:0] next_rr(input logic [1:0] g);
        logic [1:0] p;
        p = g + 2'd1;
`ifdef HCP_REPORT_PRIO_EN
        if (p == 2'd0) begin
            p = 2'd1;
        end
`endif
        return p;
    endfunction

endpackage

// File: rtl/hcp_report_sched_if.sv
// Bundle between the report sources / parse stage and the scheduler.
// master: scheduler side, slave: sources + parse stage side.
interface hcp_report_sched_if import hcp_report_sched_pkg::*; ();

    logic [SRC_NUM-1:0]   iv_src_req;
    logic [SRC_NUM-1:0]   iv_src_mask;
    logic [8*SRC_NUM-1:0] iv_src_data;
    logic [SRC_NUM-1:0]   iv_src_last;
    logic [SRC_NUM-1:0]   ov_src_rd;
    logic                 o_report_en;
    logic                 i_report_en_ack;
    logic [7:0]           ov_data_csm;
    logic                 o_data_csm_last;
    logic [SRC_NUM-1:0]   ov_grant;
    logic                 o_len_err;
    logic                 i_err_clr;
    logic [1:0]           ov_sched_state;

    modport master (
        input  iv_src_req, iv_src_mask, iv_src_data, iv_src_last,
        input  i_report_en_ack, i_err_clr,
        output ov_src_rd, o_report_en, ov_data_csm, o_data_csm_last,
        output ov_grant, o_len_err, ov_sched_state
    );

    modport slave (
        output iv_src_req, iv_src_mask, iv_src_data, iv_src_last,
        output i_report_en_ack, i_err_clr,
        input  ov_src_rd, o_report_en, ov_data_csm, o_data_csm_last,
        input  ov_grant, o_len_err, ov_sched_state
    );

endinterface

// File: rtl/hcp_rr_arb4.sv
// Combinational 4-way round-robin pick: first eligible source searching
// upward (mod 4) from rr_ptr, returned one-hot.
// With HCP_REPORT_PRIO_EN defined, source 0 wins outright when eligible and
// the rotation covers only sources 1..3 (rr_ptr of 0 is treated as 1).
module hcp_rr_arb4 import hcp_report_sched_pkg::*; (
    input  logic [SRC_NUM-1:0] eligible,
    input  logic [1:0]         rr_ptr,
    output logic [SRC_NUM-1:0] grant
);

`ifdef HCP_REPORT_PRIO_EN
    logic [1:0] base;
    logic [1:0] second;
    logic [1:0] third;

    // Rotation order over sources 1..3 starting at the pointer.
    always_comb begin
        base   = (rr_ptr == 2'd0) ? 2'd1 : rr_ptr;
        second = (base == 2'd3) ? 2'd1 : base + 2'd1;
        third  = (second == 2'd3) ? 2'd1 : second + 2'd1;
    end

    // Strict priority for the CSM source, round-robin for the rest.
    always_comb begin
        grant = '0;
        if (eligible[SRC_CSM]) begin
            grant = 4'b0001;
        end else if (eligible[base]) begin
            grant = 4'b0001 << base;
        end else if (eligible[second]) begin
            grant = 4'b0001 << second;
        end else if (eligible[third]) begin
            grant = 4'b0001 << third;
        end
    end
`else
    logic [SRC_NUM-1:0] rot;
    logic [1:0]         off;

    // rot[i] is the eligibility of the source i steps above the pointer.
    for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_rot
        assign rot[gi] = eligible[rr_ptr + 2'(gi)];
    end

    // First eligible offset, then rotate back to an absolute one-hot grant.
    always_comb begin
        grant = '0;
        off   = 2'd0;
        casez (rot)
            4'b???1: off = 2'd0;
            4'b??10: off = 2'd1;
            4'b?100: off = 2'd2;
            4'b1000: off = 2'd3;
            default: off = 2'd0;
        endcase
        if (rot != 4'd0) begin
            grant = 4'b0001 << (rr_ptr + off);
        end
    end
`endif

endmodule

// File: rtl/hcp_report_sched.sv
// Round-robin scheduler sharing the HCP report path between four report
// sources. Grants one pending source, runs the report_en/ack handshake with
// the parse stage, then streams that source's bytes with a frame-length guard
// (1-byte frames are padded to 2 bytes, frames longer than MAX_LEN are cut).
// Build option HCP_REPORT_PRIO_EN: source 0 gets strict priority.
module hcp_report_sched import hcp_report_sched_pkg::*; #(
    parameter int MAX_LEN = 256
) (
    input  logic           i_clk,
    input  logic           i_rst,
    hcp_report_sched_if.master bus
);

    localparam logic [8:0] LAST_CNT = 9'(MAX_LEN - 1);

    sched_state_t       state_reg, state_next;
    logic [SRC_NUM-1:0] grant_reg, grant_next;
    logic [1:0]         gidx_reg, gidx_next;
    logic [1:0]         rr_ptr_reg, rr_ptr_next;
    logic [8:0]         byte_cnt_reg, byte_cnt_next;
    logic               report_en_reg, report_en_next;
    logic               len_err_reg, len_err_next;

    logic [SRC_NUM-1:0] eligible;
    logic [SRC_NUM-1:0] arb_grant;
    logic [7:0]         head_byte [SRC_NUM];
    logic [7:0]         g_byte;
    logic               g_last;
    logic               force_last;
    logic               frame_end;
    logic               err_set;

    logic [7:0]         data_out;
    logic               last_out;
    logic [SRC_NUM-1:0] rd_out;

    for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_head
        assign head_byte[gi] = bus.iv_src_data[8*gi +: 8];
    end

    assign eligible   = bus.iv_src_req & bus.iv_src_mask;
    assign g_byte     = head_byte[gidx_reg];
    assign g_last     = bus.iv_src_last[gidx_reg];
    assign force_last = (byte_cnt_reg == LAST_CNT);
    assign frame_end  = (state_reg == STREAM_S) && (g_last || force_last);

    hcp_rr_arb4 u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_reg),
        .grant    (arb_grant)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE_S;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; ack only matters while waiting for it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE_S:   if (eligible != 4'd0)     state_next = REQ_S;
            REQ_S:    if (bus.i_report_en_ack)  state_next = STREAM_S;
            STREAM_S: if (frame_end)            state_next = IDLE_S;
            default:                            state_next = IDLE_S;
        endcase
    end

    // Data path outputs: mux of the granted head byte. A short frame is not
    // popped on the ack cycle so its only byte is shown again as the last one.
    always_comb begin
        data_out = 8'd0;
        last_out = 1'b0;
        rd_out   = '0;
        case (state_reg)
            REQ_S: begin
                data_out = g_byte;
                if (bus.i_report_en_ack && !g_last) begin
                    rd_out = grant_reg;
                end
            end
            STREAM_S: begin
                data_out = g_byte;
                last_out = g_last || force_last;
                rd_out   = grant_reg;
            end
            default: ;
        endcase
    end

    // Next values of the registered grant, pointer, counter and error flag.
    always_comb begin
        grant_next     = grant_reg;
        gidx_next      = gidx_reg;
        rr_ptr_next    = rr_ptr_reg;
        byte_cnt_next  = byte_cnt_reg;
        report_en_next = report_en_reg;
        err_set        = 1'b0;
        case (state_reg)
            IDLE_S: begin
                if (eligible != 4'd0) begin
                    grant_next     = arb_grant;
                    gidx_next      = onehot_to_idx(arb_grant);
                    report_en_next = 1'b1;
                    byte_cnt_next  = 9'd0;
                end
            end
            REQ_S: begin
                if (bus.i_report_en_ack) begin
                    report_en_next = 1'b0;
                    byte_cnt_next  = 9'd1;
                    err_set        = g_last;
                end
            end
            STREAM_S: begin
                byte_cnt_next = byte_cnt_reg + 9'd1;
                err_set       = force_last && !g_last;
                if (frame_end) begin
                    rr_ptr_next   = next_rr(gidx_reg);
                    grant_next    = '0;
                    byte_cnt_next = 9'd0;
                end
            end
            default: ;
        endcase
        // A new error outranks a simultaneous clear.
        len_err_next = err_set || (len_err_reg && !bus.i_err_clr);
    end

    // Registers for grant, pointer, counter, report_en and the sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_reg     <= '0;
            gidx_reg      <= 2'd0;
            rr_ptr_reg    <= 2'd0;
            byte_cnt_reg  <= 9'd0;
            report_en_reg <= 1'b0;
            len_err_reg   <= 1'b0;
        end else begin
            grant_reg     <= grant_next;
            gidx_reg      <= gidx_next;
            rr_ptr_reg    <= rr_ptr_next;
            byte_cnt_reg  <= byte_cnt_next;
            report_en_reg <= report_en_next;
            len_err_reg   <= len_err_next;
        end
    end

    assign bus.ov_src_rd       = rd_out;
    assign bus.ov_data_csm     = data_out;
    assign bus.o_data_csm_last = last_out;
    assign bus.o_report_en     = report_en_reg;
    assign bus.ov_grant        = grant_reg;
    assign bus.o_len_err       = len_err_reg;
    assign bus.ov_sched_state  = state_reg;

endmodule
